// File: rtl/booth_mac_acc.sv
// booth_mac_acc: radix-4 Booth 8x8 signed multiply-accumulate with valid/ready input and result ports.
// Define BOOTH_MAC_SAT_EN to clamp the accumulator on signed overflow; otherwise it wraps.

module R4Mult8by8 (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] product
);
  logic [8:0]  w_b_ext;
  logic [15:0] w_a_ext;
  logic [15:0] w_pp;
  logic [15:0] w_sum;
  logic [2:0]  w_trip;

  assign w_b_ext = {b, 1'b0};
  assign w_a_ext = {{8{a[7]}}, a};

  // Each overlapping bit triplet of b selects one of {0, +-a, +-2a} at weight 4^i.
  always_comb begin
    w_sum  = '0;
    w_pp   = '0;
    w_trip = '0;
    for (int i = 0; i < 4; i++) begin
      w_trip = 3'(w_b_ext >> (2 * i));
      case (w_trip)
        3'b001, 3'b010: w_pp = w_a_ext;
        3'b011:         w_pp = w_a_ext << 1;
        3'b100:         w_pp = -(w_a_ext << 1);
        3'b101, 3'b110: w_pp = -w_a_ext;
        default:        w_pp = '0;
      endcase
      w_sum = w_sum + (w_pp << (2 * i));
    end
  end

  assign product = w_sum;
endmodule

module booth_mac_acc #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic             r_s1_last;
  logic             r_s1_valid;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_accept;
  logic             w_clear;
  logic [15:0]      w_prod;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_raw_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_add_ovf;
  logic [CNT_W-1:0] w_cnt_next;

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_clear  = (r_state == ST_HOLD) && out_ready;

  R4Mult8by8 u_mult (
    .a       (r_s1_a),
    .b       (r_s1_b),
    .product (w_prod)
  );

  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
  assign w_raw_sum  = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_raw_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Overflow direction follows the shared operand sign.
  assign w_acc_next = !w_add_ovf ? w_raw_sum :
                      (w_prod_ext[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
  assign w_acc_next = w_raw_sum;
`endif

  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_last  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_s1_valid) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_ovf <= r_ovf | w_add_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ACC;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC:   if (w_accept && in_last) r_state <= ST_FLUSH;
        ST_FLUSH: r_state <= ST_HOLD;
        ST_HOLD:  if (out_ready) r_state <= ST_ACC;
        default:  r_state <= ST_ACC;
      endcase
      // The final add lands on the FLUSH->HOLD edge; capture its result directly.
      if (r_s1_valid && r_s1_last) begin
        r_out_sum   <= w_acc_next;
        r_out_count <= w_cnt_next;
        r_out_ovf   <= r_ovf | w_add_ovf;
      end
    end
  end
endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: directed and random dot products against an integer reference model,
// using a 24-bit and an 18-bit accumulator instance driven in lockstep.
module tb_booth_mac_acc;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        in_ready18, out_valid18, out_ovf18;
  logic [17:0] out_sum18;
  logic [7:0]  out_count18;

  int n_checks = 0;
  int n_fail   = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  booth_mac_acc #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  booth_mac_acc #(.ACC_W(18), .CNT_W(8)) dut18 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready18),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid18),
    .out_ready(out_ready), .out_sum(out_sum18), .out_count(out_count18), .out_ovf(out_ovf18)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Dot product of the queued pairs in a w-bit signed accumulator.
  function automatic void model(input int w, output longint sum, output longint cnt,
                                output longint ovf);
    longint acc = 0;
    longint s, lo, hi;
    lo  = -(longint'(1) << (w - 1));
    hi  = (longint'(1) << (w - 1)) - 1;
    ovf = 0;
    foreach (qa[i]) begin
      s = acc + longint'(qa[i] * qb[i]);
      if (s > hi || s < lo) begin
        ovf = 1;
`ifdef BOOTH_MAC_SAT_EN
        s = (s > hi) ? hi : lo;
`else
        s = (s > hi) ? s - (hi - lo + 1) : s + (hi - lo + 1);
`endif
      end
      acc = s;
    end
    sum = acc;
    cnt = (qa.size() > 255) ? 255 : qa.size();
  endfunction

  task automatic push_pair(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++)
      push_pair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
  endtask

  // Called at a negedge; feeds the queued pairs, checks the result, releases it after `hold` extra cycles.
  task automatic run_sum(input string tag, input int hold);
    longint es, ec, eo, es18, ec18, eo18, held;
    int guard;
    model(24, es, ec, eo);
    model(18, es18, ec18, eo18);
    out_ready = (hold == 0);
    foreach (qa[i]) begin
      in_valid = 1'b1;
      in_a     = 8'(qa[i]);
      in_b     = 8'(qb[i]);
      in_last  = (i == qa.size() - 1);
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk({tag, "_in_ready_timeout"}, 0, 1);
      @(negedge clk);
    end
    in_valid = (hold > 0);
    in_a     = 8'($urandom_range(0, 255));
    in_b     = 8'($urandom_range(0, 255));
    in_last  = 1'($urandom_range(0, 1));
    chk({tag, "_flush_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_flush_in_ready"}, longint'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_out_valid"}, longint'(out_valid), 1);
    chk({tag, "_sum"}, longint'($signed(out_sum)), es);
    chk({tag, "_count"}, longint'(out_count), ec);
    chk({tag, "_ovf"}, longint'(out_ovf), eo);
    chk({tag, "_out_valid18"}, longint'(out_valid18), 1);
    chk({tag, "_sum18"}, longint'($signed(out_sum18)), es18);
    chk({tag, "_count18"}, longint'(out_count18), ec18);
    chk({tag, "_ovf18"}, longint'(out_ovf18), eo18);
    held = longint'($signed(out_sum));
    for (int h = 0; h < hold; h++) begin
      in_a    = 8'($urandom_range(0, 255));
      in_b    = 8'($urandom_range(0, 255));
      in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, "_hold_out_valid"}, longint'(out_valid), 1);
      chk({tag, "_hold_in_ready"}, longint'(in_ready), 0);
      chk({tag, "_hold_sum"}, longint'($signed(out_sum)), held);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    chk({tag, "_release_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_release_in_ready"}, longint'(in_ready), 1);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);

    push_pair(3, 4); push_pair(-5, 6); push_pair(7, -8);
    run_sum("basic", 0);

    push_pair(-128, -128);
    run_sum("neg_neg", 0);
    push_pair(127, -128);
    run_sum("pos_neg", 0);

    for (int i = 0; i < 8; i++) push_pair(-128, -128);
    run_sum("ovf8", 0);

    push_random(4);
    run_sum("hold", 5);
    push_random(3);
    run_sum("after_hold", 0);

    // Reset while the last term of a partial sum of 50 sits in stage 1.
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd10; in_last = 1'b0;
    @(negedge clk);
    in_a = 8'd1; in_b = 8'd1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("rstflush_in_flush", longint'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk("rstflush_in_ready", longint'(in_ready), 1);
    chk("rstflush_sum", longint'(out_sum), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstflush_no_valid", longint'(out_valid), 0);
    end
    push_pair(2, 3);
    run_sum("after_rst", 0);

    for (int r = 0; r < 4; r++) begin
      push_random(int'($urandom_range(1, 12)));
      run_sum("random", 0);
    end

    for (int i = 0; i < 300; i++) push_pair(1, 1);
    run_sum("cnt_sat", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Sequential multiply-accumulate stage directly downstream of `R4Mult8by8`. It accepts signed 8-bit operand pairs over a valid/ready handshake and registers them into the multiplier's inputs. It accumulates the signed 16-bit products into a wide accumulator and presents the finished dot product on a valid/ready output port when the term flagged `in_last` has been added. It is the first sequential consumer of the Booth multiplier and feeds the lab's result-display / register-file logic.

## Interface
- `ACC_W`, 24, accumulator and result width in bits (≥17)
- `CNT_W`, 8, term-counter width in bits
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-high; clears all state
- `in_valid` input 1 — operand pair present
- `in_ready` output 1 — block can accept a pair this cycle
- `in_a` input 8 — signed multiplicand
- `in_b` input 8 — signed multiplier
- `in_last` input 1 — this pair is the final term of the current sum
- `out_valid` output 1 — `out_sum` holds a finished result
- `out_ready` input 1 — consumer takes the result
- `out_sum` output ACC_W — signed accumulated result
- `out_count` output CNT_W — number of terms in the result, saturating at 2^CNT_W−1
- `out_ovf` output 1 — sticky: signed overflow occurred in at least one add of this result

## Operation
- One `R4Mult8by8` instance. Its inputs `a`/`b` come from stage-1 registers `s1_a`/`s1_b`. Its 16-bit signed product is sign-extended to ACC_W.
- FSM states:
  - **ACC**: `in_ready`=1.
  - **FLUSH**: last term is in stage 1; `in_ready`=0.
  - **HOLD**: `out_valid`=1; `in_ready`=0.
- Accept = `in_valid && in_ready`. On accept: load `s1_a`, `s1_b`, `s1_last`, and set `s1_valid`=1. Otherwise `s1_valid`=0.
- Each edge with `s1_valid`=1: `acc <= acc + sext(prod)`, `cnt <= sat(cnt+1)`, and set `ovf` if the signed add overflows.
- Transitions:
  - ACC→FLUSH on accept with `in_last`=1.
  - FLUSH→HOLD on the next edge. That edge also performs the last add and copies the results into the `out_*` registers.
  - HOLD→ACC when `out_ready`=1. On that edge `acc`, `cnt` and `ovf` clear to 0.
- `out_*` values remain stable throughout HOLD. `in_valid` is ignored outside ACC.
- A sum whose first pair has `in_last`=1 is a single-term result. `out_count` is 1.
- Overflow:
  - Detection: both operand signs equal and the result sign differs.
  - Behaviour on overflow depends on MAC_SAT_EN (see Configuration).
  - Once in saturation, later adds continue from the clamped value.
- Reset mid-operation, including during FLUSH or HOLD: partial sum is discarded, FSM goes to ACC, and no `out_valid` pulse is produced.

## Timing
- Reset values: `in_ready`=1 (state ACC), `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0. All internal registers are 0.
- `in_ready`, `out_valid` are decoded directly from FSM state. There is no combinational path from `in_valid` or `out_ready` to either.
- Latency: the `in_last` pair is accepted at edge k. `out_valid` rises after edge k+1, so the result is visible in cycle k+1.
- Throughput: one pair per cycle in ACC. A result costs 2 dead input cycles (FLUSH + at least one HOLD cycle).
- The earliest next accept is the cycle after the HOLD→ACC edge.
- The multiplier path is a single register-to-register cycle: `s1_*` → Booth product → adder → `acc`.

## Configuration
- `BOOTH_MAC_SAT_EN` defined: on overflow, `acc` clamps to +(2^(ACC_W−1)−1) or −2^(ACC_W−1) according to the operand sign, and `ovf` is set.
- Undefined: `acc` wraps modulo 2^ACC_W, and `ovf` is still set.
- Port list is identical in both builds.

## Test plan
- Reset, then pairs (3,4),(−5,6),(7,−8,last) with `out_ready`=1:
  - `out_sum`=−74, `out_count`=3, `out_ovf`=0.
  - `out_valid` high exactly 1 cycle, starting the cycle after the edge following the last accept.
- Single pair (−128,−128,last): `out_sum`=16384, `out_count`=1. Then (127,−128,last) gives −16256. Confirms the Booth corner cases and the accumulator clear.
- ACC_W=18, eight pairs of (−128,−128), last on the 8th:
  - With BOOTH_MAC_SAT_EN: `out_sum`=131071, `out_ovf`=1.
  - Without it: `out_sum`=−131072, `out_ovf`=1.
- Hold `out_ready`=0 for 5 cycles after the result, keeping `in_valid`=1 with new pairs:
  - `out_sum` stays stable and `in_ready`=0 throughout; no pairs are accepted.
  - Raising `out_ready` returns to ACC, and the next sum starts from 0.
- Assert `reset` while in FLUSH with partial sum 50: `out_valid` never rises. A following (2,3,last) yields 6, count 1.
- 300 pairs of (1,1) with CNT_W=8: `out_sum`=300, `out_count`=255 (saturated).
